// File: rtl/median_pkg.sv
// Shared constants and FSM encoding for the 5x5 median frame sequencer.
package median_pkg;
  localparam int PIX_W    = 8;
  localparam int WIN_N    = 25;
  localparam int WIN_BITS = 200;
  localparam int LB_COUNT = 4;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
endpackage

// File: rtl/Filter_Median.sv
// Combinational median of 25 packed 8-bit samples.
// The median is the sample with at most 12 smaller and at least 13 smaller-or-equal samples.
module Filter_Median (
  input  logic [199:0] image_in,
  output logic [7:0]   median_out
);
  always_comb begin
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] n_lt;
    logic [4:0] n_le;
    median_out = '0;
    a          = '0;
    b          = '0;
    n_lt       = '0;
    n_le       = '0;
    for (int i = 0; i < 25; i++) begin
      a    = image_in[8*i +: 8];
      n_lt = '0;
      n_le = '0;
      for (int j = 0; j < 25; j++) begin
        b = image_in[8*j +: 8];
        if (b < a)  n_lt = n_lt + 5'd1;
        if (b <= a) n_le = n_le + 5'd1;
      end
      if (n_lt <= 5'd12 && n_le >= 5'd13) median_out = a;
    end
  end
endmodule

// File: rtl/median_line_buffer.sv
// One image row of pixel storage; read returns the old contents while the write
// at the same address lands on the clock edge.
module median_line_buffer #(
  parameter int DEPTH = 64,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdat,
  output logic [W-1:0]  o_rdat
);
  logic [W-1:0] r_mem [DEPTH];

  assign o_rdat = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdat;
  end
endmodule

// File: rtl/median_frame_sequencer.sv
// Streams a raster frame through a 5x5 median; one registered output per interior pixel,
// 1 cycle after the accepting edge. A held output stalls input until out_ready.
module median_frame_sequencer #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             busy,
  output logic             done
);
  import median_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(LB_COUNT);
  localparam logic [RW-1:0] ROW_WIN  = RW'(LB_COUNT);

  state_t                r_state;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [WIN_BITS-1:0]   r_win;
  logic [WIN_BITS-1:0]   w_win_next;
  logic                  r_out_vld;
  logic [PIX_W-1:0]      r_out_pix;
  logic                  r_busy;
  logic                  r_done;
  logic [PIX_W-1:0]      w_median;
  logic                  w_accept;
  logic                  w_complete;
  logic                  w_last;
  logic [PIX_W-1:0]      w_lb_rd [LB_COUNT];
  logic [PIX_W-1:0]      w_lb_wd [LB_COUNT];

  assign in_ready   = (r_state == RUN) && (!r_out_vld || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_complete = (r_row >= ROW_WIN) && (r_col >= COL_WIN);
  assign w_last     = (r_row == ROW_LAST) && (r_col == COL_LAST);

  assign out_valid = r_out_vld;
  assign out_pixel = r_out_pix;
  assign busy      = r_busy;
  assign done      = r_done;

  // lb0 holds the previous row; each older buffer takes the one above it
  for (genvar g = 0; g < LB_COUNT; g++) begin : g_lb
    if (g == 0) begin : g_head
      assign w_lb_wd[g] = in_pixel;
    end else begin : g_tail
      assign w_lb_wd[g] = w_lb_rd[g-1];
    end
    median_line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) u_lb (
      .clk    (clk),
      .i_we   (w_accept),
      .i_addr (r_col),
      .i_wdat (w_lb_wd[g]),
      .o_rdat (w_lb_rd[g])
    );
  end

  // Byte r*5+c: row 0 is the oldest line, column 0 the oldest column
  always_comb begin
    w_win_next = r_win;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_win_next[PIX_W*(r*5+c) +: PIX_W] = r_win[PIX_W*(r*5+c+1) +: PIX_W];
      end
    end
    for (int r = 0; r < LB_COUNT; r++) begin
      w_win_next[PIX_W*(r*5+4) +: PIX_W] = w_lb_rd[LB_COUNT-1-r];
    end
    w_win_next[PIX_W*(LB_COUNT*5+4) +: PIX_W] = in_pixel;
  end

  Filter_Median u_med (
    .image_in   (w_win_next),
    .median_out (w_median)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_win     <= '0;
      r_out_vld <= 1'b0;
      r_out_pix <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_accept && w_complete) begin
        r_out_vld <= 1'b1;
        r_out_pix <= w_median;
      end else if (out_ready) begin
        r_out_vld <= 1'b0;
      end

      if (w_accept) begin
        r_win <= w_win_next;
        if (r_col == COL_LAST) begin
          r_col <= '0;
          if (r_row != ROW_LAST) r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end

      case (r_state)
        IDLE: if (start) begin
          r_state <= RUN;
          r_col   <= '0;
          r_row   <= '0;
          r_busy  <= 1'b1;
        end
        RUN: if (w_accept && w_last) r_state <= FLUSH;
        FLUSH: if (!r_out_vld || out_ready) begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_median_frame_sequencer.sv
// Frame-level bench for median_frame_sequencer on an 8x8 image with a median scoreboard.
module tb_median_frame_sequencer;
  localparam int W    = 8;
  localparam int H    = 8;
  localparam int NPIX = W * H;

  typedef struct {
    int pat;        // 0 constant, 1 ramp, 2 impulse
    int cv;
    int stall_at;   // output index to hold out_ready low at, -1 none
    bit start_mid;
    int exp_first;
    int exp_last;
    int exp_hold;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pixel;
  logic       busy;
  logic       done;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] img [NPIX];
  logic [7:0] exp_q [$];
  vec_t       vecs [5];
  vec_t       v7;

  always #5 clk = ~clk;

  median_frame_sequencer #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int pat, input int cv);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pat)
          0:       img[r*W+c] = 8'(cv);
          1:       img[r*W+c] = 8'(r*W + c);
          default: img[r*W+c] = (r == 3 && c == 3) ? 8'd255 : (r == 4 && c == 4) ? 8'd0 : 8'd10;
        endcase
  endtask

  // Sort-based reference median of the 5x5 block ending at (r,c)
  function automatic logic [7:0] model_median(input int r, input int c);
    logic [7:0] s [25];
    logic [7:0] t;
    int n = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        s[n] = img[(r-4+i)*W + (c-4+j)];
        n++;
      end
    for (int i = 1; i < 25; i++)
      for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
        t = s[j]; s[j] = s[j-1]; s[j-1] = t;
      end
    return s[12];
  endfunction

  task automatic run_frame(input vec_t v, input int max_in, input bit full);
    int idx = 0, cyc = 0, n_out = 0, stall_cnt = 0, n_done = 0;
    int acc36 = -1, first_vld = -1, last_pop = -1, done_cyc = -1;
    logic [31:0] first_val = 0, last_val = 0;
    logic [7:0]  e;
    bit busy_checked = 0;
    fill(v.pat, v.cv);
    exp_q.delete();
    while (cyc < 2000) begin
      @(negedge clk);
      start     = (cyc == 0) || (v.start_mid && idx == 10);
      out_ready = !(v.stall_at >= 0 && out_valid && n_out == v.stall_at && stall_cnt < 3);
      in_valid  = (idx < max_in);
      in_pixel  = (idx < max_in) ? img[idx] : 8'h00;
      #1;
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (out_valid && !out_ready) begin
        stall_cnt++;
        check("stall_hold", out_pixel, v.exp_hold);
        check("stall_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        check("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_pixel", out_pixel, e);
        end
        if (n_out == 0) first_val = out_pixel;
        last_val = out_pixel;
        n_out++;
        last_pop = cyc;
      end
      if (in_valid && in_ready) begin
        if (idx / W >= 4 && idx % W >= 4) exp_q.push_back(model_median(idx / W, idx % W));
        if (idx == 36) acc36 = cyc;
        idx++;
      end
      if (full && idx == 20 && !busy_checked) begin
        check("busy_mid", busy, 1);
        busy_checked = 1;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      cyc++;
      if (!full && idx == max_in) break;
      if (done_cyc >= 0 && cyc - done_cyc > 3) break;
    end
    if (full) begin
      check("frame_done_seen", done_cyc >= 0, 1);
      check("out_count", n_out, 16);
      check("first_val", first_val, v.exp_first);
      check("last_val", last_val, v.exp_last);
      check("first_latency", first_vld, acc36 + 1);
      check("done_pulses", n_done, 1);
      check("done_delay", (done_cyc - last_pop >= 1) && (done_cyc - last_pop <= 2), 1);
      check("busy_end", busy, 0);
      check("queue_empty", exp_q.size(), 0);
      if (v.stall_at >= 0) check("stall_cycles", stall_cnt, 3);
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  initial begin
    vecs[0] = '{0, 'h55, -1, 0, 'h55, 'h55, 0};
    vecs[1] = '{1, 0,    -1, 0, 18,   45,   0};
    vecs[2] = '{2, 0,    -1, 0, 10,   10,   0};
    vecs[3] = '{1, 0,     1, 0, 18,   45,   19};
    vecs[4] = '{1, 0,    -1, 1, 18,   45,   0};
    v7      = '{0, 7,    -1, 0, 7,    7,    0};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_pixel = 8'h00; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_frame(vecs[i], NPIX, 1'b1);

    run_frame(vecs[1], 30, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_pixel", out_pixel, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("idle_wait_busy", busy, 0);
    check("idle_wait_in_ready", in_ready, 0);
    check("idle_wait_out_valid", out_valid, 0);
    run_frame(v7, NPIX, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
